// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS link checker: LFSR tap masks, seed helper, checker states.
package prbs_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } chk_state_e;

  // Fibonacci tap masks; bit i set means stage i+1 feeds the XOR.
  localparam logic [31:0] TAPS_8  = 32'h0000_00B8;  // x^8  + x^6  + x^5  + x^4 + 1
  localparam logic [31:0] TAPS_16 = 32'h0000_B400;  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [31:0] TAPS_24 = 32'h00E1_0000;  // x^24 + x^23 + x^22 + x^17 + 1
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;  // x^32 + x^22 + x^2  + x^1 + 1

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return TAPS_8;
      24:      return TAPS_24;
      32:      return TAPS_32;
      default: return TAPS_16;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_seed(input int width);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) s[i] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR with all-ones seed; steps once per advance strobe, reload has priority.
// Word output is registered state, valid the cycle after the strobe; no flow control of its own.
module prbs_lfsr #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 advance,
  input  logic                 reload,
  output logic [OUT_WIDTH-1:0] word
);
  import prbs_pkg::*;

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED = WIDTH'(lfsr_seed(WIDTH));

  logic [WIDTH-1:0] state_q, state_d;
  logic             feedback;

  always_comb begin
    feedback = ^(state_q & TAPS);
    state_d  = state_q;
    if (reload) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = {state_q[WIDTH-2:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign word = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/prbs_link_checker.sv
// PRBS generator plus lock/compare checker; status is registered one cycle after each rx word.
// Tx is valid/ready (word held while stalled); rx has no backpressure. PRBS_LINK_CHECKER_INJECT_EN adds an error-inject input.
module prbs_link_checker #(
  parameter int DATA_WIDTH       = 8,
  parameter int LFSR_WIDTH       = 16,
  parameter int ERR_CNT_WIDTH    = 16,
  parameter int RELOCK_THRESHOLD = 4,
  parameter int STOP_ON_ERROR    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
`ifdef PRBS_LINK_CHECKER_INJECT_EN
  input  logic                     inject,
`endif
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     locked,
  output logic                     error,
  output logic                     lost_lock,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ERR_CNT_WIDTH-1:0] word_count
);
  import prbs_pkg::*;

  if (DATA_WIDTH < 1 || DATA_WIDTH > LFSR_WIDTH) begin : g_bad_data_width
    $error("DATA_WIDTH must be in 1..LFSR_WIDTH");
  end
  if (LFSR_WIDTH != 8 && LFSR_WIDTH != 16 && LFSR_WIDTH != 24 && LFSR_WIDTH != 32) begin : g_bad_lfsr_width
    $error("LFSR_WIDTH must be 8, 16, 24 or 32");
  end
  if (RELOCK_THRESHOLD < 1 || RELOCK_THRESHOLD > 15) begin : g_bad_threshold
    $error("RELOCK_THRESHOLD must be in 1..15");
  end

  localparam logic [3:0]               THRESH  = 4'(RELOCK_THRESHOLD);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]    gen_word, exp_word;
  logic                     gen_advance, exp_advance, exp_reload, rx_match;
  chk_state_e               state_q, state_d;
  logic                     run_q, run_d;
  logic                     error_q, error_d;
  logic                     lost_q, lost_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [3:0]               miss_q, miss_d;

  // run_q keeps tx_valid low while reset is held even if enable is already high.
  assign tx_valid    = run_q && enable && !((STOP_ON_ERROR != 0) && error_q);
  assign gen_advance = tx_valid && tx_ready && !clear;

  prbs_lfsr #(.WIDTH(LFSR_WIDTH), .OUT_WIDTH(DATA_WIDTH)) u_gen_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (gen_advance),
    .reload  (clear),
    .word    (gen_word)
  );

  prbs_lfsr #(.WIDTH(LFSR_WIDTH), .OUT_WIDTH(DATA_WIDTH)) u_exp_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (exp_advance),
    .reload  (exp_reload),
    .word    (exp_word)
  );

`ifdef PRBS_LINK_CHECKER_INJECT_EN
  // Corrupts only the outgoing copy; the generator sequence is untouched.
  assign tx_data = gen_word ^ DATA_WIDTH'(inject);
`else
  assign tx_data = gen_word;
`endif

  assign rx_match = (rx_data == exp_word);

  always_comb begin
    run_d       = 1'b1;
    state_d     = state_q;
    error_d     = error_q;
    lost_d      = lost_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    miss_d      = miss_q;
    exp_advance = 1'b0;
    exp_reload  = 1'b0;

    if (clear) begin
      state_d    = ST_SEARCH;
      error_d    = 1'b0;
      lost_d     = 1'b0;
      err_cnt_d  = '0;
      word_cnt_d = '0;
      miss_d     = '0;
      exp_reload = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_SEARCH: begin
          if (rx_match) begin
            state_d     = ST_LOCKED;
            exp_advance = 1'b1;
            miss_d      = '0;
          end
        end
        ST_LOCKED: begin
          exp_advance = 1'b1;
          word_cnt_d  = word_cnt_q + CNT_ONE;
          if (rx_match) begin
            miss_d = '0;
          end else begin
            error_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
            miss_d = miss_q + 4'd1;
            // Reload wins over advance inside the LFSR, so the search restarts from the seed.
            if (miss_q + 4'd1 == THRESH) begin
              state_d    = ST_SEARCH;
              exp_reload = 1'b1;
              lost_d     = 1'b1;
              miss_d     = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      state_q    <= ST_SEARCH;
      error_q    <= 1'b0;
      lost_q     <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
      miss_q     <= '0;
    end else begin
      run_q      <= run_d;
      state_q    <= state_d;
      error_q    <= error_d;
      lost_q     <= lost_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
      miss_q     <= miss_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign error      = error_q;
  assign lost_lock  = lost_q;
  assign err_count  = err_cnt_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_prbs_link_checker.sv
// Directed bench for prbs_link_checker: three parameterisations, scoreboard of expected status per rx word.
module tb_prbs_link_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Instance A: defaults, tx looped back to rx with an optional corruption mask.
  logic        a_enable, a_clear, a_tx_ready, a_tx_valid, a_rx_valid, a_locked, a_error, a_lost;
  logic [7:0]  a_tx_data, a_rx_data, a_corrupt;
  logic [15:0] a_err_cnt, a_word_cnt;
  assign a_rx_data  = a_tx_data ^ a_corrupt;
  assign a_rx_valid = a_tx_valid && a_tx_ready;

  // Instance B: STOP_ON_ERROR = 0, directed rx or loopback.
  logic        b_enable, b_clear, b_tx_ready, b_tx_valid, b_rx_valid, b_locked, b_error, b_lost;
  logic        b_lb, b_rx_vld_drv;
  logic [7:0]  b_tx_data, b_rx_data, b_rx_drv;
  logic [15:0] b_err_cnt, b_word_cnt;
`ifdef PRBS_LINK_CHECKER_INJECT_EN
  logic        b_inject;
`endif
  assign b_rx_data  = b_lb ? b_tx_data : b_rx_drv;
  assign b_rx_valid = b_lb ? (b_tx_valid && b_tx_ready) : b_rx_vld_drv;

  // Instance C: 4-bit counters, threshold 15.
  logic        c_enable, c_clear, c_tx_ready, c_tx_valid, c_rx_valid, c_locked, c_error, c_lost;
  logic [7:0]  c_tx_data, c_rx_data;
  logic [3:0]  c_err_cnt, c_word_cnt;

  prbs_link_checker u_a (
    .clk(clk), .reset_n(reset_n), .enable(a_enable), .clear(a_clear),
`ifdef PRBS_LINK_CHECKER_INJECT_EN
    .inject(1'b0),
`endif
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .locked(a_locked), .error(a_error),
    .lost_lock(a_lost), .err_count(a_err_cnt), .word_count(a_word_cnt)
  );

  prbs_link_checker #(.STOP_ON_ERROR(0)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(b_enable), .clear(b_clear),
`ifdef PRBS_LINK_CHECKER_INJECT_EN
    .inject(b_inject),
`endif
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .locked(b_locked), .error(b_error),
    .lost_lock(b_lost), .err_count(b_err_cnt), .word_count(b_word_cnt)
  );

  prbs_link_checker #(.ERR_CNT_WIDTH(4), .RELOCK_THRESHOLD(15), .STOP_ON_ERROR(0)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(c_enable), .clear(c_clear),
`ifdef PRBS_LINK_CHECKER_INJECT_EN
    .inject(1'b0),
`endif
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .locked(c_locked), .error(c_error),
    .lost_lock(c_lost), .err_count(c_err_cnt), .word_count(c_word_cnt)
  );

  typedef struct {
    string       tag;
    logic        locked;
    logic        error;
    logic        lost;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;
  } exp_t;

  exp_t sb_q[$];

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
  function automatic logic [15:0] nxt16(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic lk, input logic er, input logic ls,
                      input logic [15:0] ec, input logic [15:0] wc);
    exp_t e;
    e.tag = tag; e.locked = lk; e.error = er; e.lost = ls; e.err_cnt = ec; e.word_cnt = wc;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int inst);
    exp_t        e;
    logic        lk, er, ls;
    logic [15:0] ec, wc;
    chk("sb_not_empty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    case (inst)
      0:       begin lk = a_locked; er = a_error; ls = a_lost; ec = a_err_cnt; wc = a_word_cnt; end
      1:       begin lk = b_locked; er = b_error; ls = b_lost; ec = b_err_cnt; wc = b_word_cnt; end
      default: begin lk = c_locked; er = c_error; ls = c_lost; ec = 16'(c_err_cnt); wc = 16'(c_word_cnt); end
    endcase
    chk({e.tag, ".locked"},     32'(lk), 32'(e.locked));
    chk({e.tag, ".error"},      32'(er), 32'(e.error));
    chk({e.tag, ".lost_lock"},  32'(ls), 32'(e.lost));
    chk({e.tag, ".err_count"},  32'(ec), 32'(e.err_cnt));
    chk({e.tag, ".word_count"}, 32'(wc), 32'(e.word_cnt));
  endtask

  task automatic b_send(input logic [7:0] w);
    b_rx_drv = w; b_rx_vld_drv = 1'b1;
    step();
    b_rx_vld_drv = 1'b0;
  endtask

  task automatic c_send(input logic [7:0] w);
    c_rx_data = w; c_rx_valid = 1'b1;
    step();
    c_rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] g, e, bexp, errexp;
    logic [7:0]  early_words [4];
    int          words, cyc;
    logic        hs, stalled;

    early_words[0] = 8'hFF; early_words[1] = 8'hFE; early_words[2] = 8'hFC; early_words[3] = 8'hF8;

    reset_n = 1'b0;
    a_enable = 1'b1; a_clear = 1'b0; a_tx_ready = 1'b0; a_corrupt = 8'h00;
    b_enable = 1'b0; b_clear = 1'b0; b_tx_ready = 1'b1; b_lb = 1'b0; b_rx_drv = 8'h00; b_rx_vld_drv = 1'b0;
`ifdef PRBS_LINK_CHECKER_INJECT_EN
    b_inject = 1'b0;
`endif
    c_enable = 1'b0; c_clear = 1'b0; c_tx_ready = 1'b1; c_rx_data = 8'h00; c_rx_valid = 1'b0;

    // Reset values, with enable already high on A.
    repeat (2) @(negedge clk);
    chk("rst.tx_data",    32'(a_tx_data),  32'hFF);
    chk("rst.tx_valid",   32'(a_tx_valid), 32'd0);
    chk("rst.locked",     32'(a_locked),   32'd0);
    chk("rst.error",      32'(a_error),    32'd0);
    chk("rst.lost_lock",  32'(a_lost),     32'd0);
    chk("rst.err_count",  32'(a_err_cnt),  32'd0);
    chk("rst.word_count", 32'(a_word_cnt), 32'd0);
    reset_n = 1'b1;

    // Loopback on A: 1001 words; the first locks from SEARCH, the next 1000 are counted.
    g = 16'hFFFF; words = 0; cyc = 0; stalled = 1'b0;
    while (words < 1001 && cyc < 6000) begin
      if (words == 100 && !stalled) begin
        stalled = 1'b1; a_tx_ready = 1'b0;
        repeat (5) begin
          step(); cyc++;
          chk("stall.tx_data",  32'(a_tx_data),  32'(g[7:0]));
          chk("stall.tx_valid", 32'(a_tx_valid), 32'd1);
        end
      end
      a_tx_ready = ($urandom_range(0, 3) != 0);
      hs = a_tx_valid && a_tx_ready;
      if (hs) begin
        chk("loop.tx_data", 32'(a_tx_data), 32'(g[7:0]));
        if (words < 4) chk("loop.early_word", 32'(a_tx_data), 32'(early_words[words]));
        push("loop", 1'b1, 1'b0, 1'b0, 16'd0, 16'(words));
        g = nxt16(g); words++;
      end
      step(); cyc++;
      if (hs) pop_check(0);
    end
    a_tx_ready = 1'b0;
    chk("loop.words_sent", 32'(words),      32'd1001);
    chk("loop.word_count", 32'(a_word_cnt), 32'd1000);

    // One corrupted word (bit 3) on A; tx must halt the following cycle.
    a_tx_ready = 1'b1; a_corrupt = 8'h08;
    chk("corrupt.tx_data", 32'(a_tx_data), 32'(g[7:0]));
    push("corrupt", 1'b1, 1'b1, 1'b0, 16'd1, 16'd1001);
    step();
    a_corrupt = 8'h00;
    pop_check(0);
    chk("corrupt.tx_valid_now", 32'(a_tx_valid), 32'd0);
    g = nxt16(g);
    repeat (3) step();
    chk("corrupt.tx_valid_later", 32'(a_tx_valid), 32'd0);
    chk("corrupt.tx_data_held",   32'(a_tx_data),  32'(g[7:0]));
    chk("corrupt.word_count",     32'(a_word_cnt), 32'd1001);

    // Clear on A restores reset values; enable is high and error is gone, so tx_valid returns.
    a_clear = 1'b1; a_tx_ready = 1'b0;
    step();
    a_clear = 1'b0;
    chk("a_clear.tx_data",    32'(a_tx_data),  32'hFF);
    chk("a_clear.tx_valid",   32'(a_tx_valid), 32'd1);
    chk("a_clear.locked",     32'(a_locked),   32'd0);
    chk("a_clear.error",      32'(a_error),    32'd0);
    chk("a_clear.err_count",  32'(a_err_cnt),  32'd0);
    chk("a_clear.word_count", 32'(a_word_cnt), 32'd0);

    // B: lock, then four consecutive misses drop lock.
    b_enable = 1'b1;
    e = 16'hFFFF;
    push("b_lock", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    b_send(8'hFF); pop_check(1); e = nxt16(e);
    push("b_match", 1'b1, 1'b0, 1'b0, 16'd0, 16'd1);
    b_send(e[7:0]); pop_check(1); e = nxt16(e);
    for (int i = 1; i <= 4; i++) begin
      push("b_miss", (i < 4), 1'b1, (i == 4), 16'(i), 16'(1 + i));
      b_send(e[7:0] ^ 8'h01); pop_check(1); e = nxt16(e);
    end
    chk("b_no_stop.tx_valid", 32'(b_tx_valid), 32'd1);
    push("b_search_discard", 1'b0, 1'b1, 1'b1, 16'd4, 16'd5);
    b_send(8'h12); pop_check(1);
    push("b_relock", 1'b1, 1'b1, 1'b1, 16'd4, 16'd5);
    b_send(8'hFF); pop_check(1);
    e = nxt16(16'hFFFF);
    push("b_after_relock", 1'b1, 1'b1, 1'b1, 16'd4, 16'd6);
    b_send(e[7:0]); pop_check(1); e = nxt16(e);

    // Clear wins over a concurrent valid word.
    b_clear = 1'b1;
    push("b_clear_prio", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    b_send(e[7:0]);
    b_clear = 1'b0;
    pop_check(1);
    push("b_clear_relock", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    b_send(8'hFF); pop_check(1);
    bexp = 16'hFFFE;

`ifdef PRBS_LINK_CHECKER_INJECT_EN
    // Loopback on B with bit 0 of the tenth word inverted.
    b_clear = 1'b1; b_lb = 1'b1;
    step();
    b_clear = 1'b0;
    g = 16'hFFFF; words = 0; cyc = 0;
    while (words < 30 && cyc < 200) begin
      b_inject = (words == 9);
      hs = b_tx_valid && b_tx_ready;
      if (hs) begin
        chk("inj.tx_data", 32'(b_tx_data), 32'(g[7:0] ^ {7'b0, b_inject}));
        push("inj", 1'b1, (words >= 9), 1'b0, (words >= 9) ? 16'd1 : 16'd0, 16'(words));
        g = nxt16(g); words++;
      end
      step(); cyc++;
      if (hs) pop_check(1);
    end
    b_inject = 1'b0; b_lb = 1'b0; b_enable = 1'b0;
    chk("inj.words_sent", 32'(words), 32'd30);
    bexp = g;
    push("b_pre_reset", 1'b1, 1'b1, 1'b0, 16'd2, 16'd30);
`else
    b_enable = 1'b0;
    push("b_pre_reset", 1'b1, 1'b1, 1'b0, 16'd1, 16'd1);
`endif
    b_send(bexp[7:0] ^ 8'h01); pop_check(1);
    bexp = nxt16(bexp);

    // C: saturating 4-bit error counter with interleaved matches; lock must hold.
    e = 16'hFFFF;
    push("c_lock", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    c_send(8'hFF); pop_check(2); e = nxt16(e);
    for (int i = 1; i <= 20; i++) begin
      errexp = (i > 15) ? 16'd15 : 16'(i);
      push("c_miss", 1'b1, 1'b1, 1'b0, errexp, 16'((2 * i - 1) % 16));
      c_send(e[7:0] ^ 8'h80); pop_check(2); e = nxt16(e);
      push("c_match", 1'b1, 1'b1, 1'b0, errexp, 16'((2 * i) % 16));
      c_send(e[7:0]); pop_check(2); e = nxt16(e);
    end
    c_clear = 1'b1;
    step();
    c_clear = 1'b0;
    chk("c_clear.tx_data",    32'(c_tx_data),  32'hFF);
    chk("c_clear.tx_valid",   32'(c_tx_valid), 32'd0);
    chk("c_clear.locked",     32'(c_locked),   32'd0);
    chk("c_clear.error",      32'(c_error),    32'd0);
    chk("c_clear.lost_lock",  32'(c_lost),     32'd0);
    chk("c_clear.err_count",  32'(c_err_cnt),  32'd0);
    chk("c_clear.word_count", 32'(c_word_cnt), 32'd0);

    // Reset asserted mid-word on B: the pending mismatch must not land.
    b_rx_drv = bexp[7:0] ^ 8'h01; b_rx_vld_drv = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.locked",     32'(b_locked),   32'd0);
    chk("midrst.error",      32'(b_error),    32'd0);
    chk("midrst.err_count",  32'(b_err_cnt),  32'd0);
    chk("midrst.word_count", 32'(b_word_cnt), 32'd0);
    @(negedge clk);
    b_rx_vld_drv = 1'b0;
    chk("midrst_held.err_count",  32'(b_err_cnt),  32'd0);
    chk("midrst_held.word_count", 32'(b_word_cnt), 32'd0);
    reset_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
